// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, 1-cycle-latency imem request/response, and a 2-entry
// output FIFO with valid/ready handshake and single-cycle redirect flush.
//
// state | meaning
// EMPTY | no buffered instruction
// ONE   | one buffered instruction
// FULL  | two buffered instructions
module fetch_stage #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16,
    parameter int OPC_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [OPC_W-1:0]  out_opcode,
    output logic [ADDR_W-1:0] out_pc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

    fifo_state_t       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [INST_W-1:0] inst_mem_q [2];
    logic [INST_W-1:0] inst_mem_d [2];
    logic [ADDR_W-1:0] pcs_mem_q  [2];
    logic [ADDR_W-1:0] pcs_mem_d  [2];

    logic credit_ok;
    logic push;
    logic pop;

    // Credit counts both buffered entries and the response still in flight.
    assign credit_ok = (state_q == EMPTY) || ((state_q == ONE) && !inflight_q);
    assign imem_req  = rst_n & en & ~redirect & credit_ok;
    assign imem_addr = pc_q;

    assign out_valid  = (state_q != EMPTY);
    assign out_inst   = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign out_pc     = out_valid ? pcs_mem_q[rd_ptr_q]  : '0;
    assign out_opcode = out_valid ? inst_mem_q[rd_ptr_q][INST_W-1 -: OPC_W] : '0;

    assign pop  = out_valid & out_ready;
    assign push = inflight_q & ~redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = 1'b0;
        req_addr_d = req_addr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inst_mem_d = inst_mem_q;
        pcs_mem_d  = pcs_mem_q;

        if (redirect) begin
            // Squashes the in-flight response and everything but an accepted head.
            state_d  = EMPTY;
            pc_d     = redirect_pc;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (imem_req) begin
                pc_d       = pc_q + ADDR_W'(1);
                inflight_d = 1'b1;
                req_addr_d = pc_q;
            end
            if (push) begin
                inst_mem_d[wr_ptr_q] = imem_rdata;
                pcs_mem_d[wr_ptr_q]  = req_addr_q;
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case (state_q)
                EMPTY:   if (push)         state_d = ONE;
                ONE:     if (push && !pop) state_d = FULL;
                         else if (!push && pop) state_d = EMPTY;
                FULL:    if (!push && pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            req_addr_q    <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            inst_mem_q[0] <= '0;
            inst_mem_q[1] <= '0;
            pcs_mem_q[0]  <= '0;
            pcs_mem_q[1]  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inst_mem_q <= inst_mem_d;
            pcs_mem_q  <= pcs_mem_d;
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && state_q == FULL));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked against a
// queue-based reference model of the fetch pipeline.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_inst;
    logic [5:0]  out_opcode;
    logic [7:0]  out_pc;

    fetch_stage #(.ADDR_W(8), .INST_W(16), .OPC_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_opcode(out_opcode), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];

    // Synchronous instruction memory; junk on the bus when not read.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
        else          imem_rdata <= 16'($urandom);
    end

    typedef struct {
        logic [15:0] inst;
        logic [7:0]  pc;
    } ent_t;

    ent_t        m_q[$];
    logic [7:0]  m_pc;
    bit          m_infl;
    logic [7:0]  m_infl_addr;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc        = '0;
        m_infl      = 1'b0;
        m_infl_addr = '0;
    endtask

    // Asserted mid-cycle so the async path is exercised; released at a negedge with en=0.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_imem_req",   32'(imem_req),   32'h0);
        check("rst_imem_addr",  32'(imem_addr),  32'h0);
        check("rst_out_valid",  32'(out_valid),  32'h0);
        check("rst_out_opcode", 32'(out_opcode), 32'h0);
        check("rst_out_inst",   32'(out_inst),   32'h0);
        check("rst_out_pc",     32'(out_pc),     32'h0);
        model_reset();
        en = 1'b0;
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic e, input logic r, input logic [7:0] rpc, input logic rdy);
        logic exp_req;
        logic exp_valid;
        @(negedge clk);
        en = e;
        redirect = r;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
        exp_req   = e && !r && ((m_q.size() + int'(m_infl)) < 2);
        exp_valid = (m_q.size() > 0);
        check("imem_req",  32'(imem_req),  32'(exp_req));
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_inst",   32'(out_inst),   32'(m_q[0].inst));
            check("out_pc",     32'(out_pc),     32'(m_q[0].pc));
            check("out_opcode", 32'(out_opcode), 32'(m_q[0].inst[15:10]));
        end else begin
            check("out_opcode_idle", 32'(out_opcode), 32'h0);
        end
        if (r) begin
            m_q.delete();
            m_pc   = rpc;
            m_infl = 1'b0;
        end else begin
            if (exp_valid && rdy) void'(m_q.pop_front());
            if (m_infl) m_q.push_back('{inst: mem[m_infl_addr], pc: m_infl_addr});
            m_infl = exp_req;
            if (exp_req) begin
                m_infl_addr = m_pc;
                m_pc        = m_pc + 8'd1;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0400 | 16'(a);
        model_reset();
        en = 1'b1;

        // Streaming from reset
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Backpressure from cycle 0, then drain
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Redirect with a buffered entry and a request in flight
        do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h80, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Redirect while full, including a same-cycle pop
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Wrap-around
        step(1'b1, 1'b1, 8'hFE, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Back-to-back redirects: last one wins
        step(1'b1, 1'b1, 8'h10, 1'b1);
        step(1'b1, 1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // en low for 5 cycles mid-stream
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Async reset while out_valid=1, then restart at 0
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

        // Random traffic on random memory contents
        do_reset();
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) != 0, ($urandom % 16) == 0, 8'($urandom), ($urandom % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
